// File: rtl/mod_exp_pkg.sv
// Shared definitions for the modular exponentiation engine: FSM state encoding
// and a width helper for cycle counters.
package mod_exp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REDUCE = 3'd1,
    ST_MUL    = 3'd2,
    ST_SQR    = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mod_mul_serial.sv
// Interleaved bit-serial modular multiplier: prod = a*b mod p in WIDTH cycles,
// scanning multiplier bits MSB first. prod_o/done_o are valid in the final step cycle.
module mod_mul_serial
  import mod_exp_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] p_i,
  output logic             done_o,
  output logic [WIDTH-1:0] prod_o
);

  localparam int CW = clog2(WIDTH);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] bsh_q, bsh_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             run_q, run_d;

  logic [WIDTH-1:0] a_use, p_use, acc_in, acc_nx;
  logic [WIDTH+1:0] sum;
  logic             mbit;

  // acc < p and addend < p, so 2*acc + addend < 3p: at most two subtractions restore acc < p.
  function automatic logic [WIDTH-1:0] reduce2(input logic [WIDTH+1:0] v,
                                               input logic [WIDTH-1:0] m);
    logic [WIDTH+1:0] t;
    t = v;
    if (t >= {2'b00, m}) t = t - {2'b00, m};
    else t = t;
    if (t >= {2'b00, m}) t = t - {2'b00, m};
    else t = t;
    return t[WIDTH-1:0];
  endfunction

  // The start cycle computes its step straight from the ports so no load cycle is lost.
  always_comb begin
    a_use  = start_i ? a_i : a_q;
    p_use  = start_i ? p_i : p_q;
    acc_in = start_i ? '0 : acc_q;
    mbit   = start_i ? b_i[WIDTH-1] : bsh_q[WIDTH-1];
    sum    = {1'b0, acc_in, 1'b0} + {2'b00, (mbit ? a_use : {WIDTH{1'b0}})};
    acc_nx = reduce2(sum, p_use);
    prod_o = acc_nx;
  end

  // Step sequencing and operand capture.
  always_comb begin
    acc_d  = acc_q;
    a_d    = a_q;
    bsh_d  = bsh_q;
    p_d    = p_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    done_o = 1'b0;
    if (start_i) begin
      a_d    = a_i;
      p_d    = p_i;
      bsh_d  = b_i << 1;
      acc_d  = acc_nx;
      cnt_d  = CW'(1);
      run_d  = (WIDTH > 1);
      done_o = (WIDTH == 1);
    end else if (run_q) begin
      acc_d = acc_nx;
      bsh_d = bsh_q << 1;
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(WIDTH - 1)) begin
        run_d  = 1'b0;
        done_o = 1'b1;
      end else begin
        run_d = 1'b1;
      end
    end else begin
      run_d = 1'b0;
    end
  end

  // Datapath registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      acc_q <= '0;
      a_q   <= '0;
      bsh_q <= '0;
      p_q   <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      a_q   <= a_d;
      bsh_q <= bsh_d;
      p_q   <= p_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/mod_exp_engine.sv
// Constant-time right-to-left square-and-multiply: result = g^x mod p.
// Optional error flag output enabled by defining MOD_EXP_ERR_EN.
module mod_exp_engine
  import mod_exp_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int EXP_WIDTH = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  input  logic [WIDTH-1:0]     g,
  input  logic [EXP_WIDTH-1:0] x,
  input  logic [WIDTH-1:0]     p,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     result
`ifdef MOD_EXP_ERR_EN
  ,
  output logic                 err
`endif
);

  localparam int RCW = clog2(WIDTH + 1);
  localparam int ECW = clog2(EXP_WIDTH + 1);

  state_t               state_q, state_d;
  logic [RCW-1:0]       cnt_q, cnt_d;
  logic [ECW-1:0]       ecnt_q, ecnt_d;
  logic [WIDTH-1:0]     g_q, g_d;
  logic [EXP_WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0]     p_q, p_d;
  logic [WIDTH-1:0]     r_q, r_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 launch_q, launch_d;
`ifdef MOD_EXP_ERR_EN
  logic                 err_q, err_d;
`endif

  logic             accept;
  logic             p_small;
  logic [WIDTH:0]   div_t;
  logic [WIDTH-1:0] div_rem;
  logic [WIDTH-1:0] mm_a, mm_prod;
  logic             mm_done;

  assign p_small = (p_q[WIDTH-1:1] == '0);
  assign mm_a    = (state_q == ST_SQR) ? b_q : r_q;

  mod_mul_serial #(.WIDTH(WIDTH)) u_mul (
    .CLK    (CLK),
    .RST    (RST),
    .start_i(launch_q),
    .a_i    (mm_a),
    .b_i    (b_q),
    .p_i    (p_q),
    .done_o (mm_done),
    .prod_o (mm_prod)
  );

  // Restoring-division step for REDUCE; b_q doubles as the partial remainder.
  always_comb begin
    div_t = {b_q, g_q[WIDTH-1]};
    if (div_t >= {1'b0, p_q}) div_rem = WIDTH'(div_t - {1'b0, p_q});
    else div_rem = WIDTH'(div_t);
  end

  // Next-state logic. REDUCE spends its first cycle on the p<2 decision.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ecnt_d   = ecnt_q;
    g_d      = g_q;
    x_d      = x_q;
    p_d      = p_q;
    r_d      = r_q;
    b_d      = b_q;
    result_d = result_q;
    done_d   = 1'b0;
    launch_d = 1'b0;
    accept   = 1'b0;
`ifdef MOD_EXP_ERR_EN
    err_d    = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          g_d     = g;
          x_d     = x;
          p_d     = p;
          r_d     = WIDTH'(1);
          b_d     = '0;
          cnt_d   = '0;
          ecnt_d  = '0;
          state_d = ST_REDUCE;
`ifdef MOD_EXP_ERR_EN
          err_d   = 1'b0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REDUCE: begin
        if (cnt_q == '0) begin
          if (p_small) state_d = ST_DONE;
          else cnt_d = cnt_q + RCW'(1);
        end else begin
          b_d = div_rem;
          g_d = g_q << 1;
          if (cnt_q == RCW'(WIDTH)) begin
            state_d  = ST_MUL;
            launch_d = 1'b1;
          end else begin
            cnt_d = cnt_q + RCW'(1);
          end
        end
      end
      ST_MUL: begin
        // Product always computed; commit only on a set exponent bit.
        if (mm_done) begin
          r_d      = x_q[0] ? mm_prod : r_q;
          state_d  = ST_SQR;
          launch_d = 1'b1;
        end else begin
          state_d = ST_MUL;
        end
      end
      ST_SQR: begin
        if (mm_done) begin
          b_d = mm_prod;
          x_d = x_q >> 1;
          if (ecnt_q == ECW'(EXP_WIDTH - 1)) begin
            state_d = ST_DONE;
          end else begin
            ecnt_d   = ecnt_q + ECW'(1);
            state_d  = ST_MUL;
            launch_d = 1'b1;
          end
        end else begin
          state_d = ST_SQR;
        end
      end
      ST_DONE: begin
        done_d   = 1'b1;
        result_d = p_small ? '0 : r_q;
        state_d  = ST_IDLE;
`ifdef MOD_EXP_ERR_EN
        err_d    = p_small;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_q != ST_IDLE) || accept;
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      ecnt_q   <= '0;
      g_q      <= '0;
      x_q      <= '0;
      p_q      <= '0;
      r_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      launch_q <= 1'b0;
`ifdef MOD_EXP_ERR_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ecnt_q   <= ecnt_d;
      g_q      <= g_d;
      x_q      <= x_d;
      p_q      <= p_d;
      r_q      <= r_d;
      b_q      <= b_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      launch_q <= launch_d;
`ifdef MOD_EXP_ERR_EN
      err_q    <= err_d;
`endif
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
`ifdef MOD_EXP_ERR_EN
  assign err    = err_q;
`endif

endmodule

// File: tb/tb_mod_exp_engine.sv
// Self-checking bench for mod_exp_engine against a plain-arithmetic modexp model.
// Define MOD_EXP_ERR_EN to also check the err output.
module tb_mod_exp_engine;

  localparam int W   = 32;
  localparam int E   = 32;
  localparam int LAT = W * (2 * E + 1) + 2;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] g = '0;
  logic [E-1:0] x = '0;
  logic [W-1:0] p = '0;
  logic         busy, done;
  logic [W-1:0] result;
`ifdef MOD_EXP_ERR_EN
  logic         err;
`endif

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  mod_exp_engine #(.WIDTH(W), .EXP_WIDTH(E)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .start (start),
    .g     (g),
    .x     (x),
    .p     (p),
    .busy  (busy),
    .done  (done),
    .result(result)
`ifdef MOD_EXP_ERR_EN
    ,
    .err   (err)
`endif
  );

  function automatic logic [W-1:0] ref_modexp(input logic [W-1:0] gg, input logic [E-1:0] xx,
                                              input logic [W-1:0] pp);
    longint unsigned r, b, m;
    if (pp < 2) return '0;
    m = 64'(pp);
    r = 1;
    b = 64'(gg) % m;
    for (int i = 0; i < E; i++) begin
      if (xx[i]) r = (r * b) % m;
      b = (b * b) % m;
    end
    return r[W-1:0];
  endfunction

  // Launch one op; after acceptance inputs are scrambled (and start toggled if noisy).
  task automatic run_op(input logic [W-1:0] gg, input logic [E-1:0] xx, input logic [W-1:0] pp,
                        input bit noisy, output logic [W-1:0] res, output int lat,
                        output bit busy_ok);
    start = 1'b1; g = gg; x = xx; p = pp;
    @(posedge CLK); #1;
    start = 1'b0; g = $urandom; x = $urandom; p = $urandom;
    lat = 0; busy_ok = 1'b1; res = 'x;
    while (lat < LAT + 20) begin
      @(posedge CLK); #1;
      lat++;
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) begin
        res = result;
        break;
      end
      if (noisy) begin
        start = 1'($urandom_range(0, 1)); g = $urandom; x = $urandom; p = $urandom;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (result !== '0) begin errors++; $display("FAIL reset_result: got %0d want 0", result); end
`ifdef MOD_EXP_ERR_EN
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
`endif
    RST = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_known();
    logic [W-1:0] res; int lat; bit bok;
    logic [W-1:0] tg [3] = '{32'd5, 32'd30, 32'd2};
    logic [E-1:0] tx [3] = '{32'd6, 32'd3, 32'd0};
    logic [W-1:0] tp [3] = '{32'd23, 32'd7, 32'd11};
    logic [W-1:0] te [3] = '{32'd8, 32'd1, 32'd1};
    for (int i = 0; i < 3; i++) begin
      run_op(tg[i], tx[i], tp[i], 1'b0, res, lat, bok);
      checks++; if (res !== te[i]) begin errors++; $display("FAIL known%0d_result: got %0d want %0d", i, res, te[i]); end
      checks++; if (lat != LAT) begin errors++; $display("FAIL known%0d_latency: got %0d want %0d", i, lat, LAT); end
      checks++; if (!bok) begin errors++; $display("FAIL known%0d_busy: got low want high throughout", i); end
`ifdef MOD_EXP_ERR_EN
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL known%0d_err: got %b want 0", i, err); end
`endif
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_fast_path();
    logic [W-1:0] res; int lat; bit bok;
    logic [W-1:0] tp [2] = '{32'd1, 32'd0};
    for (int i = 0; i < 2; i++) begin
      run_op(32'd7, 32'd5, tp[i], 1'b0, res, lat, bok);
      checks++; if (res !== '0) begin errors++; $display("FAIL fast%0d_result: got %0d want 0", i, res); end
      checks++; if (lat != 2) begin errors++; $display("FAIL fast%0d_latency: got %0d want 2", i, lat); end
`ifdef MOD_EXP_ERR_EN
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL fast%0d_err: got %b want 1", i, err); end
`endif
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_random();
    logic [W-1:0] res, exp, rg, rp; logic [E-1:0] rx; int lat; bit bok;
    for (int i = 0; i < 13; i++) begin
      if (i == 0) begin
        rg = 32'hFFFF_FFFF; rx = 32'hFFFF_FFFF; rp = 32'hFFFF_FFFB;
      end else begin
        rg = $urandom; rx = $urandom;
        rp = (i % 3 == 0) ? 32'($urandom_range(2, 1000)) : $urandom;
        if (rp < 2) rp = rp + 32'd2;
      end
      exp = ref_modexp(rg, rx, rp);
      run_op(rg, rx, rp, 1'b0, res, lat, bok);
      checks++; if (res !== exp) begin errors++; $display("FAIL rand%0d_result g=%h x=%h p=%h: got %h want %h", i, rg, rx, rp, res, exp); end
      checks++; if (lat != LAT) begin errors++; $display("FAIL rand%0d_latency: got %0d want %0d", i, lat, LAT); end
      checks++; if (!bok) begin errors++; $display("FAIL rand%0d_busy: got low want high throughout", i); end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_busy_ignore();
    logic [W-1:0] res, prev, exp; int lat; bit bok;
    prev = result;
    exp = ref_modexp(32'd123457, 32'h0000_BEEF, 32'd1000003);
    start = 1'b1; g = 32'd123457; x = 32'h0000_BEEF; p = 32'd1000003;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (10) begin @(posedge CLK); #1; end
    checks++; if (result !== prev) begin errors++; $display("FAIL hold_result: got %h want %h", result, prev); end
    // Remaining cycles: a fresh run_op would re-start, so finish the op with noisy inputs here.
    lat = 11; bok = 1'b1; res = 'x;
    while (lat < LAT + 20) begin
      if (busy !== 1'b1) bok = 1'b0;
      start = 1'($urandom_range(0, 1)); g = $urandom; x = $urandom; p = $urandom;
      @(posedge CLK); #1;
      start = 1'b0;
      if (done === 1'b1) begin res = result; break; end
      lat++;
    end
    checks++; if (res !== exp) begin errors++; $display("FAIL noisy_result: got %h want %h", res, exp); end
    checks++; if (lat != LAT) begin errors++; $display("FAIL noisy_latency: got %0d want %0d", lat, LAT); end
    checks++; if (!bok) begin errors++; $display("FAIL noisy_busy: got low want high throughout"); end
    @(posedge CLK); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL no_queue_busy: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] res, exp; int lat; bit bok;
    run_op(32'd3, 32'd200, 32'd1000, 1'b0, res, lat, bok);
    exp = ref_modexp(32'd3, 32'd200, 32'd1000);
    checks++; if (res !== exp) begin errors++; $display("FAIL b2b_first: got %0d want %0d", res, exp); end
    run_op(32'd77, 32'hDEAD_BEEF, 32'hFFFF_FFF1, 1'b0, res, lat, bok);
    exp = ref_modexp(32'd77, 32'hDEAD_BEEF, 32'hFFFF_FFF1);
    checks++; if (res !== exp) begin errors++; $display("FAIL b2b_second: got %h want %h", res, exp); end
    checks++; if (lat != LAT) begin errors++; $display("FAIL b2b_latency: got %0d want %0d", lat, LAT); end
    @(posedge CLK); #1;
  endtask

  task automatic test_mid_reset();
    logic [W-1:0] res, exp; int lat; bit bok; bit saw;
    saw = 1'b0;
    start = 1'b1; g = 32'd9; x = 32'd77; p = 32'd101;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (999) begin @(posedge CLK); #1; if (done === 1'b1) saw = 1'b1; end
    RST = 1'b0;
    @(posedge CLK); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_reset_done: got %b want 0", done); end
    checks++; if (result !== '0) begin errors++; $display("FAIL mid_reset_result: got %h want 0", result); end
    RST = 1'b1;
    repeat (LAT) begin @(posedge CLK); #1; if (done === 1'b1) saw = 1'b1; end
    checks++; if (saw) begin errors++; $display("FAIL mid_reset_no_done: got pulse want none"); end
    exp = ref_modexp(32'd40, 32'd13, 32'd97);
    run_op(32'd40, 32'd13, 32'd97, 1'b0, res, lat, bok);
    checks++; if (res !== exp) begin errors++; $display("FAIL after_reset_result: got %0d want %0d", res, exp); end
    checks++; if (lat != LAT) begin errors++; $display("FAIL after_reset_latency: got %0d want %0d", lat, LAT); end
  endtask

  initial begin
    test_reset();
    test_known();
    test_fast_path();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
